// File: rtl/clk_div_mon_pkg.sv
// rtl/clk_div_mon_pkg.sv - shared types and constants for the divided-clock monitor
//
// Purpose: monitor FSM state encoding and the width of the good-measurement counter.
// Ports:   none (package).

package clk_div_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      MEAS = 2'd2
   } state_t;

   // Holds LOCK_CNT values 1..15.
   localparam int GOOD_W = 4;

endpackage

// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - control, expectation and status bundle of the divided-clock monitor
//
// Purpose: groups the monitor's functional signals; master drives, slave (the monitor) observes.
// Ports:   en, div_in, exp_period, exp_high, err_clr          (master -> slave)
//          rise_pulse, fall_pulse, meas_valid, period_cnt,
//          high_cnt, locked, err                              (slave -> master)

interface clk_div_monitor_if #(
   parameter int CNT_W = 8
) ();

   logic             en;
   logic             div_in;
   logic [CNT_W-1:0] exp_period;
   logic [CNT_W-1:0] exp_high;
   logic             err_clr;

   logic             rise_pulse;
   logic             fall_pulse;
   logic             meas_valid;
   logic [CNT_W-1:0] period_cnt;
   logic [CNT_W-1:0] high_cnt;
   logic             locked;
   logic             err;

   modport master (
      output en, div_in, exp_period, exp_high, err_clr,
      input  rise_pulse, fall_pulse, meas_valid, period_cnt, high_cnt, locked, err
   );

   modport slave (
      input  en, div_in, exp_period, exp_high, err_clr,
      output rise_pulse, fall_pulse, meas_valid, period_cnt, high_cnt, locked, err
   );

endinterface

// File: rtl/clk_div_edge_det.sv
// rtl/clk_div_edge_det.sv - edge detector for a divided clock level sampled in the clk domain
//
// Purpose: detects rising/falling edges of div_in, suppressed until one enabled cycle has
//          passed so a level that is already high at enable does not look like an edge.
// Ports:   clk, rstn          clock, asynchronous active-low reset
//          en                 enable; low disarms detection from the next cycle
//          div_in             divided clock level
//          rise, fall         combinational detection in the current cycle
//          rise_pulse,
//          fall_pulse         registered copies, one cycle after detection

module clk_div_edge_det (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic div_in,
   output logic rise,
   output logic fall,
   output logic rise_pulse,
   output logic fall_pulse
);

   logic div_q;
   logic primed;

   assign rise = div_in & ~div_q & primed;
   assign fall = ~div_in & div_q & primed;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_q      <= 1'b0;
         primed     <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         div_q      <= div_in;
         // primed follows en by one cycle: armed only once div_q holds an enabled sample
         primed     <= en;
         rise_pulse <= rise;
         fall_pulse <= fall;
      end
   end

endmodule

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - period/high-time checker and lock/error reporter for a divided clock
//
// Purpose: measures period and high time of div_in in clk cycles between rising edges,
//          compares them with exp_period/exp_high (within TOL), declares lock after
//          LOCK_CNT consecutive matches and raises a sticky err on loss of lock or timeout.
// Ports:   clk, rstn   clock, asynchronous active-low reset
//          mon         clk_div_monitor_if slave: en, div_in, exp_period, exp_high, err_clr in;
//                      rise_pulse, fall_pulse, meas_valid, period_cnt, high_cnt, locked, err out

module clk_div_monitor
   import clk_div_mon_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4,
   parameter int TOL      = 0
) (
   input logic               clk,
   input logic               rstn,
   clk_div_monitor_if.slave  mon
);

   localparam logic [CNT_W-1:0]  PCNT_MAX = '1;
   localparam logic [CNT_W-1:0]  TOL_V    = CNT_W'(TOL);
   localparam logic [GOOD_W-1:0] LOCK_V   = GOOD_W'(LOCK_CNT);

   function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   logic rise;
   logic fall;
   logic rise_pulse_q;
   logic fall_pulse_q;

   clk_div_edge_det u_edge_det (
      .clk        (clk),
      .rstn       (rstn),
      .en         (mon.en),
      .div_in     (mon.div_in),
      .rise       (rise),
      .fall       (fall),
      .rise_pulse (rise_pulse_q),
      .fall_pulse (fall_pulse_q)
   );

   state_t              state;
   logic [CNT_W-1:0]    pcnt;
   logic [CNT_W-1:0]    hcnt;
   logic                fall_seen;
   logic [GOOD_W-1:0]   good;
   logic [GOOD_W-1:0]   good_inc;
   logic [CNT_W-1:0]    period_q;
   logic [CNT_W-1:0]    high_q;
   logic                meas_valid_q;
   logic                locked_q;
   logic                err_q;

   logic in_meas;
   logic capture;
   logic timeout;
   logic match;
   logic err_set;

   assign in_meas  = mon.en && (state == MEAS);
   assign capture  = in_meas && rise;
   // A rise on the same cycle as the terminal count is still a valid measurement.
   assign timeout  = in_meas && !rise && (pcnt == PCNT_MAX);
   assign match    = (mon.exp_period != '0)
                  && (abs_diff(pcnt, mon.exp_period) <= TOL_V)
                  && (abs_diff(hcnt, mon.exp_high) <= TOL_V);
   assign good_inc = (good == LOCK_V) ? good : good + 1'b1;
   assign err_set  = timeout || (capture && !match && locked_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= IDLE;
         pcnt         <= '0;
         hcnt         <= '0;
         fall_seen    <= 1'b0;
         good         <= '0;
         period_q     <= '0;
         high_q       <= '0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         meas_valid_q <= 1'b0;

         // set has priority over a simultaneous clear
         if (err_set) begin
            err_q <= 1'b1;
         end else if (mon.err_clr) begin
            err_q <= 1'b0;
         end

         if (!mon.en) begin
            state     <= IDLE;
            locked_q  <= 1'b0;
            good      <= '0;
            pcnt      <= '0;
            hcnt      <= '0;
            fall_seen <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  state <= SYNC;
               end
               SYNC: begin
                  if (rise) begin
                     state     <= MEAS;
                     pcnt      <= CNT_W'(1);
                     hcnt      <= CNT_W'(1);
                     fall_seen <= 1'b0;
                  end
               end
               MEAS: begin
                  if (rise) begin
                     period_q     <= pcnt;
                     high_q       <= hcnt;
                     meas_valid_q <= 1'b1;
                     if (match) begin
                        good <= good_inc;
                        if (good_inc == LOCK_V) begin
                           locked_q <= 1'b1;
                        end
                     end else begin
                        good     <= '0;
                        locked_q <= 1'b0;
                     end
                     pcnt      <= CNT_W'(1);
                     hcnt      <= CNT_W'(1);
                     fall_seen <= 1'b0;
                  end else if (timeout) begin
                     state    <= SYNC;
                     good     <= '0;
                     locked_q <= 1'b0;
                     pcnt     <= '0;
                     hcnt     <= '0;
                  end else begin
                     pcnt <= pcnt + 1'b1;
                     // high time is the first high run after the rise; later glitches are ignored
                     if (mon.div_in && !fall_seen) begin
                        hcnt <= hcnt + 1'b1;
                     end
                     if (fall) begin
                        fall_seen <= 1'b1;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign mon.rise_pulse = rise_pulse_q;
   assign mon.fall_pulse = fall_pulse_q;
   assign mon.meas_valid = meas_valid_q;
   assign mon.period_cnt = period_q;
   assign mon.high_cnt   = high_q;
   assign mon.locked     = locked_q;
   assign mon.err        = err_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - self-checking bench for clk_div_monitor (TOL=0 and TOL=1 instances)

module tb_clk_div_monitor;

   logic       clk;
   logic       rstn;
   logic       en;
   logic       div_in;
   logic       err_clr;
   logic [7:0] exp_period;
   logic [7:0] exp_high;

   clk_div_monitor_if #(.CNT_W(8)) if0 ();
   clk_div_monitor_if #(.CNT_W(8)) if1 ();

   assign if0.en = en;   assign if0.div_in = div_in;   assign if0.err_clr = err_clr;
   assign if0.exp_period = exp_period;   assign if0.exp_high = exp_high;
   assign if1.en = en;   assign if1.div_in = div_in;   assign if1.err_clr = err_clr;
   assign if1.exp_period = exp_period;   assign if1.exp_high = exp_high;

   clk_div_monitor #(.CNT_W(8), .LOCK_CNT(4), .TOL(0)) dut0 (.clk(clk), .rstn(rstn), .mon(if0));
   clk_div_monitor #(.CNT_W(8), .LOCK_CNT(4), .TOL(1)) dut1 (.clk(clk), .rstn(rstn), .mon(if1));

   logic [20:0] obs [2];
   assign obs[0] = {if0.rise_pulse, if0.fall_pulse, if0.meas_valid, if0.locked, if0.err,
                    if0.period_cnt, if0.high_cnt};
   assign obs[1] = {if1.rise_pulse, if1.fall_pulse, if1.meas_valid, if1.locked, if1.err,
                    if1.period_cnt, if1.high_cnt};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: timestamps of the last rise and first fall, per-instance tolerance.
   int tolv [2] = '{0, 1};
   int cyc;
   bit m_prev_en, m_prev_div;
   int m_mode [2];    // 0 off, 1 hunting first rise, 2 measuring
   int m_r [2];       // cycle of last rise
   int m_ff [2];      // cycle of first fall after that rise, -1 if none
   int m_good [2];
   int m_period [2];
   int m_high [2];
   bit m_locked [2], m_err [2], m_mv [2], m_rp [2], m_fp [2];
   bit stim [$];

   function automatic int absd(int a, int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic logic [20:0] expv(int k);
      logic [7:0] p, h;
      p = m_period[k][7:0];
      h = m_high[k][7:0];
      return {m_rp[k], m_fp[k], m_mv[k], m_locked[k], m_err[k], p, h};
   endfunction

   function automatic void add_per(int h, int l);
      for (int i = 0; i < h; i++) stim.push_back(1'b1);
      for (int i = 0; i < l; i++) stim.push_back(1'b0);
   endfunction

   task automatic model_reset();
      cyc = 0; m_prev_en = 0; m_prev_div = 0;
      for (int k = 0; k < 2; k++) begin
         m_mode[k] = 0; m_r[k] = 0; m_ff[k] = -1; m_good[k] = 0;
         m_period[k] = 0; m_high[k] = 0;
         m_locked[k] = 0; m_err[k] = 0; m_mv[k] = 0; m_rp[k] = 0; m_fp[k] = 0;
      end
   endtask

   task automatic model_step();
      bit rise, fall, eset, ok;
      int p, h;
      rise = m_prev_en && div_in && !m_prev_div;
      fall = m_prev_en && !div_in && m_prev_div;
      for (int k = 0; k < 2; k++) begin
         eset = 0; m_mv[k] = 0; m_rp[k] = rise; m_fp[k] = fall;
         if (!en) begin
            m_mode[k] = 0; m_locked[k] = 0; m_good[k] = 0;
         end else if (m_mode[k] == 0) begin
            m_mode[k] = 1;
         end else if (m_mode[k] == 1) begin
            if (rise) begin m_mode[k] = 2; m_r[k] = cyc; m_ff[k] = -1; end
         end else if (rise) begin
            p = cyc - m_r[k];
            h = (m_ff[k] < 0) ? p : m_ff[k] - m_r[k];
            m_period[k] = p; m_high[k] = h; m_mv[k] = 1;
            ok = (exp_period != 0) && absd(p, int'(exp_period)) <= tolv[k]
                 && absd(h, int'(exp_high)) <= tolv[k];
            if (ok) begin
               if (m_good[k] < 4) m_good[k]++;
               if (m_good[k] == 4) m_locked[k] = 1;
            end else begin
               if (m_locked[k]) eset = 1;
               m_locked[k] = 0; m_good[k] = 0;
            end
            m_r[k] = cyc; m_ff[k] = -1;
         end else if (cyc - m_r[k] == 255) begin
            eset = 1; m_locked[k] = 0; m_good[k] = 0; m_mode[k] = 1;
         end else if (fall && m_ff[k] < 0) begin
            m_ff[k] = cyc;
         end
         if (eset) m_err[k] = 1;
         else if (err_clr) m_err[k] = 0;
      end
      m_prev_en = en; m_prev_div = div_in; cyc++;
   endtask

   task automatic tick(input logic e, input logic d);
      en = e; div_in = d;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset(input logic e, input logic d);
      en = e; div_in = d; err_clr = 0;
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 0; div_in = 1'($urandom); err_clr = 0;
      exp_period = 8'd4; exp_high = 8'd2;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (obs[k] !== 21'd0) begin
            n_err++;
            $display("FAIL reset_state dut%0d got=%h want=0", k, obs[k]);
         end
      end
   endtask

   task automatic test_prime_high();
      do_reset(1'b1, 1'b1);
      stim.delete(); add_per(4, 2); add_per(1, 0);
      foreach (stim[i]) begin
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL prime_high dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
         n_chk++;
         if (if0.rise_pulse !== ((i == 6) ? 1'b1 : 1'b0)) begin
            n_err++;
            $display("FAIL prime_rise_pulse step=%0d got=%b want=%b", i, if0.rise_pulse, i == 6);
         end
      end
   endtask

   task automatic test_lock();
      int mv_n;
      exp_period = 8'd4; exp_high = 8'd2;
      do_reset(1'b1, 1'b0);
      stim.delete(); add_per(0, 2);
      for (int n = 0; n < 5; n++) add_per(2, 2);
      mv_n = 0;
      foreach (stim[i]) begin
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL lock_stream dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
         if (if0.meas_valid === 1'b1) begin
            mv_n++;
            n_chk++;
            if (mv_n == 1 && {i[7:0], if0.period_cnt, if0.high_cnt} !== {8'd6, 8'd4, 8'd2}) begin
               n_err++;
               $display("FAIL first_meas step=%0d period=%0d high=%0d want step 6 4/2",
                        i, if0.period_cnt, if0.high_cnt);
            end
            n_chk++;
            if (if0.locked !== (mv_n >= 4)) begin
               n_err++;
               $display("FAIL lock_on_4th meas#%0d got=%b want=%b", mv_n, if0.locked, mv_n >= 4);
            end
         end
      end
      n_chk++;
      if ({mv_n[3:0], if0.err} !== {4'd4, 1'b0}) begin
         n_err++;
         $display("FAIL lock_summary meas=%0d err=%b want 4 and 0", mv_n, if0.err);
      end
   endtask

   task automatic test_stretch();
      stim.delete(); add_per(3, 2);
      for (int n = 0; n < 5; n++) add_per(2, 2);
      add_per(2, 2);
      foreach (stim[i]) begin
         err_clr = (i == 25);
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL stretch dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
         if (i == 5) begin
            n_chk++;
            if ({if0.meas_valid, if0.period_cnt, if0.high_cnt, if0.err, if0.locked}
                !== {1'b1, 8'd5, 8'd3, 1'b1, 1'b0}) begin
               n_err++;
               $display("FAIL stretch_capture mv=%b p=%0d h=%0d err=%b lock=%b want 1 5 3 1 0",
                        if0.meas_valid, if0.period_cnt, if0.high_cnt, if0.err, if0.locked);
            end
         end
         if (i == 24) begin
            n_chk++;
            if ({if0.locked, if0.err} !== 2'b11) begin
               n_err++;
               $display("FAIL relock_sticky lock=%b err=%b want 1 1", if0.locked, if0.err);
            end
         end
      end
      err_clr = 0;
      n_chk++;
      if ({if0.locked, if0.err} !== 2'b10) begin
         n_err++;
         $display("FAIL err_clr_after_relock lock=%b err=%b want 1 0", if0.locked, if0.err);
      end
   endtask

   task automatic test_err_clr_race();
      stim.delete(); add_per(3, 2);
      for (int n = 0; n < 6; n++) add_per(2, 2);
      foreach (stim[i]) begin
         err_clr = (i == 5 || i == 6);
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL err_clr_race dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
         if (i == 5 || i == 6) begin
            n_chk++;
            if (if0.err !== (i == 5)) begin
               n_err++;
               $display("FAIL set_wins step=%0d err=%b want=%b", i, if0.err, i == 5);
            end
         end
      end
      err_clr = 0;
   endtask

   task automatic test_timeout();
      int mv_n;
      mv_n = 0;
      stim.delete(); add_per(0, 300);
      foreach (stim[i]) begin
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL timeout dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
         if (if0.meas_valid === 1'b1) mv_n++;
      end
      n_chk++;
      if ({mv_n[3:0], if0.err, if0.locked, if1.err} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL timeout_flags mv=%0d err=%b lock=%b err1=%b want 0 1 0 1",
                  mv_n, if0.err, if0.locked, if1.err);
      end
      mv_n = 0;
      stim.delete();
      for (int n = 0; n < 5; n++) add_per(2, 2);
      foreach (stim[i]) begin
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL timeout_restart dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
         if (if0.meas_valid === 1'b1) mv_n++;
      end
      n_chk++;
      if ({mv_n[3:0], if0.locked} !== {4'd4, 1'b1}) begin
         n_err++;
         $display("FAIL relock_after_timeout mv=%0d lock=%b want 4 1", mv_n, if0.locked);
      end
   endtask

   task automatic test_tol_en();
      int mv_n;
      exp_period = 8'd4; exp_high = 8'd2;
      tick(1'b0, 1'b0);
      mv_n = 0;
      stim.delete(); add_per(0, 2);
      for (int n = 0; n < 3; n++) begin add_per(2, 2); add_per(2, 3); end
      add_per(2, 0);
      foreach (stim[i]) begin
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL tol_alt dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
         if (if1.meas_valid === 1'b1) begin
            mv_n++;
            n_chk++;
            if (if1.locked !== (mv_n >= 4)) begin
               n_err++;
               $display("FAIL tol_lock meas#%0d got=%b want=%b", mv_n, if1.locked, mv_n >= 4);
            end
         end
      end
      tick(1'b0, 1'b0);
      n_chk++;
      if ({if1.locked, if1.meas_valid} !== 2'b00 || obs[1] !== expv(1)) begin
         n_err++;
         $display("FAIL en_drop lock=%b mv=%b want 0 0", if1.locked, if1.meas_valid);
      end
      mv_n = 0;
      stim.delete(); add_per(2, 2); add_per(2, 2);
      foreach (stim[i]) begin
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL reenable dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
         if (if1.meas_valid === 1'b1) mv_n++;
      end
      n_chk++;
      if (mv_n != 0) begin
         n_err++;
         $display("FAIL reenable_needs_sync meas=%0d want 0", mv_n);
      end
   endtask

   task automatic test_random();
      int bp, bh, p, h, extra;
      logic e;
      for (int s = 0; s < 6; s++) begin
         bp = $urandom_range(3, 8);
         bh = $urandom_range(1, bp - 1);
         exp_period = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'(bp);
         exp_high = 8'(bh);
         for (int n = 0; n < 8; n++) begin
            p = bp; h = bh;
            if ($urandom_range(0, 3) == 0) begin
               p = $urandom_range(2, 9);
               h = $urandom_range(1, p - 1);
            end
            extra = (s == 3 && n == 2) ? 260 : 0;
            for (int c = 0; c < p + extra; c++) begin
               err_clr = ($urandom_range(0, 11) == 0);
               e = ($urandom_range(0, 99) != 0);
               tick(e, c < h);
               for (int k = 0; k < 2; k++) begin
                  n_chk++;
                  if (obs[k] !== expv(k)) begin
                     n_err++;
                     $display("FAIL random dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
                  end
               end
            end
         end
      end
      err_clr = 0;
   endtask

   task automatic test_reset_mid();
      #2;
      rstn = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         n_chk++;
         if (obs[k] !== 21'd0) begin
            n_err++;
            $display("FAIL reset_mid dut%0d got=%h want=0", k, obs[k]);
         end
      end
      @(negedge clk);
      model_reset();
      rstn = 1'b1;
      stim.delete(); add_per(2, 2); add_per(2, 2);
      foreach (stim[i]) begin
         tick(1'b1, stim[i]);
         for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (obs[k] !== expv(k)) begin
               n_err++;
               $display("FAIL after_reset dut%0d cyc=%0d got=%h want=%h", k, cyc, obs[k], expv(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_prime_high();
      test_lock();
      test_stretch();
      test_err_clr_race();
      test_timeout();
      test_tol_en();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Downstream consumer of the divide-by-N clock divider output; the divided level is sampled in the same `clk` domain (no synchronizer).
- Detects rising and falling edges of the divided signal.
- Measures period and high time in `clk` cycles and checks both against programmed expectations.
- Reports lock and a sticky error; used as the on-chip sanity check for generated divided clocks.

Parameters:
- CNT_W, 8, width of the period/high counters and of the expectation inputs.
- LOCK_CNT, 4, consecutive matching measurements required to assert `locked` (range 1..15).
- TOL, 0, allowed absolute deviation in `clk` cycles for both period and high time.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  monitor enable; low forces IDLE.
- div_in  in  1  divided clock level, synchronous to `clk`.
- exp_period  in  CNT_W  expected period (N).
- exp_high  in  CNT_W  expected high cycles (N/2).
- err_clr  in  1  clears sticky `err`.
- rise_pulse  out  1  1-cycle pulse per detected rising edge.
- fall_pulse  out  1  1-cycle pulse per detected falling edge.
- meas_valid  out  1  1-cycle pulse when `period_cnt`/`high_cnt` update.
- period_cnt  out  CNT_W  last measured period.
- high_cnt  out  CNT_W  last measured high time.
- locked  out  1  LOCK_CNT consecutive matches seen.
- err  out  1  sticky mismatch/timeout flag.

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0; `primed` = 0.
- Edge detect:
  - `div_q` <= `div_in` every cycle.
  - rise = `div_in & ~div_q & primed`; fall = `~div_in & div_q & primed`.
  - `primed` sets on the first cycle with `en` = 1 after reset or IDLE, so no spurious edge fires when `div_in` is already high.
  - `rise_pulse`/`fall_pulse` are registered: asserted the cycle after the detection cycle.
- FSM:
  - IDLE: if `en` -> SYNC.
  - SYNC: on rise -> MEAS; set pcnt = 1, hcnt = 1.
  - MEAS:
    - pcnt increments every cycle.
    - hcnt increments while `div_in` = 1 and no fall has been seen since the last rise.
    - On rise: capture pcnt -> `period_cnt` and hcnt -> `high_cnt`, `meas_valid` = 1 the next cycle; then pcnt = 1, hcnt = 1.
    - Example: pattern 1100 repeating gives period 4, high 2.
  - From any state, `en` = 0 -> IDLE next cycle: `locked` = 0, good count = 0, `primed` = 0, counters cleared, `err` retained, no `meas_valid`.
- Compare, evaluated on each capture:
  - match = |period - exp_period| <= TOL AND |high - exp_high| <= TOL; unsigned compare, computed as max - min.
  - `exp_period` = 0 never matches.
  - Match: good count +1, saturating at LOCK_CNT; `locked` = 1 in the same cycle as `meas_valid` once good count reaches LOCK_CNT.
  - Mismatch while locked: `err` = 1, `locked` = 0, good count = 0.
  - Mismatch while unlocked: good count = 0; `err` unchanged.
- Timeout: if pcnt reaches 2^CNT_W - 1 without a rise, then `err` = 1, `locked` = 0, good count = 0, state -> SYNC, and no `meas_valid`. This applies in both locked and unlocked states.
- `err_clr`: clears `err` unless a set event occurs in the same cycle; set wins.
- Expectation inputs are sampled at each capture; changing them takes effect on the next measurement.
- Reset mid-operation: immediate return to reset values; a fresh SYNC is required.

Decomposition:
- Package clk_div_mon_pkg: state enum {IDLE, SYNC, MEAS}; localparam for the good-count width (4 bits).
- One sub-module, clk_div_edge_det: `div_q`, `primed`, rise/fall outputs. Reusable by other divided-clock consumers.

Test Plan:
- 1100 stream, exp 4/2, TOL 0, LOCK_CNT 4 -> first `meas_valid` 1 cycle after the 2nd rise detect with period 4, high 2; `locked` = 1 on the 4th `meas_valid`; `err` = 0 throughout.
- Release `rstn` with `div_in` = 1 -> no `rise_pulse` until a real 0->1 transition; first `rise_pulse` 1 cycle after it.
- After lock, stretch one period to 11100 -> `period_cnt` 5, `high_cnt` 3, `err` = 1, `locked` = 0; 4 further good periods -> `locked` = 1, `err` still 1 until `err_clr`.
- CNT_W = 8, hold `div_in` low 300 cycles after lock -> `err` = 1 at pcnt = 255, state SYNC, no `meas_valid`; restart the stream -> relock after 5 rises.
- `err_clr` asserted in the same cycle as a mismatch capture -> `err` remains 1; `err_clr` on the following cycle -> `err` = 0.
- TOL = 1, periods alternating 4/5 with exp_period 4 -> all match, lock after 4 measurements; drop `en` mid-period -> `locked` = 0 next cycle, no `meas_valid`, re-enable requires a new SYNC rise.
